// File: rtl/fpga_cfg_pkg.sv
// Shared constants and types for the fabric configuration loader.
//   CFG_W / field offsets : layout of the 116-bit program word
//   SYNC_BYTE, TIMEOUT    : framing parameters
//   cfg_state_t           : loader FSM states
//   err_code_t            : rejected-frame reason codes
//   cfg_word_t            : program word split into switch/connect/logic fields
package fpga_cfg_pkg;

    localparam int unsigned CFG_W     = 116;
    localparam int unsigned SW_LSB    = 52;
    localparam int unsigned CN_LSB    = 20;
    localparam int unsigned LG_LSB    = 0;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned TIMEOUT   = 1024;

    localparam int unsigned NBYTES = (CFG_W + 7) / 8;
    localparam int unsigned PAD    = NBYTES * 8 - CFG_W;
    localparam int unsigned SH_W   = NBYTES * 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2,
        COMMIT  = 2'd3
    } cfg_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CSUM    = 2'b01,
        ERR_PAD     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    typedef struct packed {
        logic [CFG_W-SW_LSB-1:0]  sw;
        logic [SW_LSB-CN_LSB-1:0] cn;
        logic [CN_LSB-LG_LSB-1:0] lg;
    } cfg_word_t;

endpackage

// File: rtl/fpga_config_loader_cfg_idle_timer.sv
// Inter-byte idle timer for the configuration loader.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_run          : frame in progress (timer counts only while high)
//   i_clear        : byte transfer this cycle; restarts the idle count
//   o_expired_c    : combinational; idle limit reached with no transfer this cycle
module cfg_idle_timer
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired_c
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] r_timer;

    // A transfer in the final cycle wins over expiry.
    assign o_expired_c = i_run && !i_clear && (r_timer == TW'(TIMEOUT_CYC - 1));

    // Idle cycle counter; held at zero outside a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (!i_run || i_clear) begin
            r_timer <= '0;
        end else if (!o_expired_c) begin
            r_timer <= r_timer + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Builds the fabric program word from a framed host byte stream.
// Frame: SYNC_BYTE, NBYTES payload bytes (MSB first), XOR checksum byte.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_in_data/valid  : byte stream input; o_in_ready accepts it
//   i_cfg_abort      : synchronous abort of the frame in progress
//   o_prog_out       : committed program word (fabric prog_in)
//   o_cfg_valid      : sticky, at least one good frame committed
//   o_cfg_done/err   : one-cycle commit / reject pulses
//   o_err_code       : reason of last reject, cleared on next SYNC
//   o_busy           : FSM not idle
module fpga_config_loader
    import fpga_cfg_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_cfg_abort,
    output logic [CFG_W-1:0] o_prog_out,
    output logic             o_cfg_valid,
    output logic             o_cfg_done,
    output logic             o_cfg_err,
    output logic [1:0]       o_err_code,
    output logic             o_busy
);

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [SH_W-1:0]  r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_csum;
    cfg_word_t        r_prog;
    logic             r_cfg_valid;
    logic             r_cfg_done;
    logic             r_cfg_err;
    err_code_t        r_err_code;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_xfer;
    logic             w_expired;
    logic             w_start;
    logic             w_shift;
    logic             w_commit;
    logic             w_err;
    err_code_t        w_err_val;

    assign w_xfer      = i_in_valid && r_in_ready;
    assign o_in_ready  = r_in_ready;
    assign o_prog_out  = r_prog;
    assign o_cfg_valid = r_cfg_valid;
    assign o_cfg_done  = r_cfg_done;
    assign o_cfg_err   = r_cfg_err;
    assign o_err_code  = r_err_code;
    assign o_busy      = r_busy;

    cfg_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT)
    ) u_idle_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       ((r_state == PAYLOAD) || (r_state == CSUM)),
        .i_clear     (w_xfer),
        .o_expired_c (w_expired)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle actions; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        w_err_val   = ERR_NONE;
        if (i_cfg_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer && (i_in_data == SYNC_BYTE)) begin
                        w_start     = 1'b1;
                        w_state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_xfer) begin
                        w_shift = 1'b1;
                        if (r_cnt == CNT_W'(NBYTES - 1)) begin
                            w_state_nxt = CSUM;
                        end
                    end else if (w_expired) begin
                        w_err       = 1'b1;
                        w_err_val   = ERR_TIMEOUT;
                        w_state_nxt = IDLE;
                    end
                end
                CSUM: begin
                    if (w_xfer) begin
                        if (i_in_data != r_csum) begin
                            w_err       = 1'b1;
                            w_err_val   = ERR_CSUM;
                            w_state_nxt = IDLE;
                        end else if (r_shadow[SH_W-1:CFG_W] != '0) begin
                            w_err       = 1'b1;
                            w_err_val   = ERR_PAD;
                            w_state_nxt = IDLE;
                        end else begin
                            w_commit    = 1'b1;
                            w_state_nxt = COMMIT;
                        end
                    end else if (w_expired) begin
                        w_err       = 1'b1;
                        w_err_val   = ERR_TIMEOUT;
                        w_state_nxt = IDLE;
                    end
                end
                COMMIT: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Shadow word, byte count and running checksum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_csum   <= '0;
        end else if (w_start) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_csum   <= '0;
        end else if (w_shift) begin
            r_shadow <= {r_shadow[SH_W-9:0], i_in_data};
            r_cnt    <= r_cnt + 1'b1;
            r_csum   <= r_csum ^ i_in_data;
        end
    end

    // Outputs; program word loads on the checksum edge so it is visible during COMMIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prog      <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_cfg_done <= w_commit;
            r_cfg_err  <= w_err;
            r_in_ready <= (w_state_nxt != COMMIT);
            r_busy     <= (w_state_nxt != IDLE);
            if (w_commit) begin
                r_prog      <= cfg_word_t'(r_shadow[CFG_W-1:0]);
                r_cfg_valid <= 1'b1;
            end
            if (w_start) begin
                r_err_code <= ERR_NONE;
            end else if (w_err) begin
                r_err_code <= w_err_val;
            end
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader with a frame-level reference model.
module tb_fpga_config_loader;
    import fpga_cfg_pkg::*;

    localparam int NB = (CFG_W + 7) / 8;

    typedef struct {
        int               kind;   // 1 = commit, 2 = reject
        int               cyc;
        logic [CFG_W-1:0] prog;
        logic [1:0]       code;
        bit               valid;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       i_in_data = 8'h00;
    logic             i_in_valid = 1'b0;
    logic             i_cfg_abort = 1'b0;
    logic             o_in_ready;
    logic [CFG_W-1:0] o_prog_out;
    logic             o_cfg_valid;
    logic             o_cfg_done;
    logic             o_cfg_err;
    logic [1:0]       o_err_code;
    logic             o_busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ev_t sb[$];
    bit  commit_cyc[int];

    logic [CFG_W-1:0] m_prog  = '0;
    bit               m_valid = 1'b0;
    logic [1:0]       m_err   = 2'b00;

    fpga_config_loader dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_cfg_abort (i_cfg_abort),
        .o_prog_out  (o_prog_out),
        .o_cfg_valid (o_cfg_valid),
        .o_cfg_done  (o_cfg_done),
        .o_cfg_err   (o_cfg_err),
        .o_err_code  (o_err_code),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected events when the DUT pulses done/err; police in_ready.
    always @(negedge clk) begin : monitor
        ev_t e;
        bit  is_commit;
        if (rst_n) begin
            if (o_cfg_done || o_cfg_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {126'd0, o_cfg_err, o_cfg_done}, 128'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ev_kind",   {126'd0, o_cfg_err, o_cfg_done}, 128'(e.kind));
                    chk("ev_cycle",  128'(cyc), 128'(e.cyc));
                    chk("prog_out",  128'(o_prog_out), 128'(e.prog));
                    chk("cfg_valid", 128'(o_cfg_valid), 128'(e.valid));
                    chk("err_code",  128'(o_err_code), 128'(e.code));
                end
            end
            is_commit = commit_cyc.exists(cyc);
            if (!o_in_ready || is_commit) begin
                chk("in_ready", 128'(o_in_ready), is_commit ? 128'd0 : 128'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte and wait until it transfers; acc_cyc = cycle of transfer.
    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int guard = 0;
        i_in_data  = b;
        i_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_in_ready) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                $display("FAIL send_byte_stall: in_ready=%0b required=1 within 100 cycles", o_in_ready);
                $fatal(1, "stall");
            end
        end
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            i_in_valid = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] pl[NB]);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NB; i++) x = x ^ pl[i];
        return x;
    endfunction

    task automatic rand_payload(output logic [7:0] pl[NB], input bit pad_bad);
        for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
        pl[0][7:4] = pad_bad ? 4'($urandom_range(15, 1)) : 4'h0;
    endtask

    // Send a full frame and predict its outcome from the frame contents.
    task automatic send_frame(input logic [7:0] pl[NB], input logic [7:0] cs,
                              input int gmax, input bit hold, input int long_gap_at);
        int                c;
        ev_t               e;
        logic [NB*8-1:0]   v;
        send_byte(SYNC_BYTE, c);
        m_err = 2'b00;
        v = '0;
        for (int i = 0; i < NB; i++) begin
            if (i == long_gap_at) gap(TIMEOUT - 1);
            else gap(int'($urandom_range(gmax, 0)));
            send_byte(pl[i], c);
            v = (v << 8) | (NB*8)'(pl[i]);
        end
        gap(int'($urandom_range(gmax, 0)));
        send_byte(cs, c);
        e.cyc = c + 1;
        if (cs !== xsum(pl)) begin
            e.kind = 2; e.code = 2'b01; m_err = 2'b01;
        end else if (pl[0][7:4] != 4'h0) begin
            e.kind = 2; e.code = 2'b10; m_err = 2'b10;
        end else begin
            e.kind = 1; e.code = 2'b00;
            m_prog  = v[CFG_W-1:0];
            m_valid = 1'b1;
            commit_cyc[c + 1] = 1'b1;
        end
        e.prog  = m_prog;
        e.valid = m_valid;
        sb.push_back(e);
        if (!hold) i_in_valid = 1'b0;
    endtask

    task automatic timeout_frame(input int k);
        int  c;
        ev_t e;
        send_byte(SYNC_BYTE, c);
        m_err = 2'b00;
        for (int i = 0; i < k; i++) send_byte(8'($urandom), c);
        i_in_valid = 1'b0;
        m_err   = 2'b11;
        e.kind  = 2;
        e.cyc   = c + TIMEOUT + 1;
        e.code  = 2'b11;
        e.prog  = m_prog;
        e.valid = m_valid;
        sb.push_back(e);
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
        chk("timeout_busy", 128'(o_busy), 128'd0);
        chk("timeout_code", 128'(o_err_code), 128'd3);
    endtask

    task automatic abort_frame(input int k);
        int c;
        send_byte(SYNC_BYTE, c);
        m_err = 2'b00;
        for (int i = 0; i < k; i++) send_byte(8'($urandom), c);
        i_cfg_abort = 1'b1;
        i_in_valid  = 1'($urandom_range(1, 0));
        i_in_data   = 8'($urandom);
        @(posedge clk);
        #1;
        i_cfg_abort = 1'b0;
        i_in_valid  = 1'b0;
        chk("abort_busy", 128'(o_busy), 128'd0);
        chk("abort_code", 128'(o_err_code), 128'(m_err));
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_prog"},     128'(o_prog_out), 128'd0);
        chk({tag, "_valid"},    128'(o_cfg_valid), 128'd0);
        chk({tag, "_done"},     128'(o_cfg_done), 128'd0);
        chk({tag, "_err"},      128'(o_cfg_err), 128'd0);
        chk({tag, "_code"},     128'(o_err_code), 128'd0);
        chk({tag, "_busy"},     128'(o_busy), 128'd0);
        chk({tag, "_in_ready"}, 128'(o_in_ready), 128'd1);
    endtask

    initial begin : stim
        logic [7:0] pl[NB];
        logic [7:0] pl2[NB];
        logic [7:0] j;
        int         c;
        int         mode;

        #12;
        check_idle_reset("reset");
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Minimal frame: prog_out = 1.
        for (int i = 0; i < NB; i++) pl[i] = 8'h00;
        pl[NB-1] = 8'h01;
        send_frame(pl, 8'h01, 0, 0, -1);
        // Same frame, wrong checksum.
        send_frame(pl, 8'h02, 1, 0, -1);
        // Pad bit set, checksum correct.
        pl[0] = 8'h10;
        send_frame(pl, xsum(pl), 0, 0, -1);

        // Timeouts in PAYLOAD and in CSUM, each followed by a good frame.
        timeout_frame(5);
        rand_payload(pl, 1'b0);
        send_frame(pl, xsum(pl), 2, 0, -1);
        timeout_frame(NB);
        rand_payload(pl, 1'b0);
        send_frame(pl, xsum(pl), 0, 0, -1);

        // Transfer on the last allowed idle cycle keeps the frame alive.
        rand_payload(pl, 1'b0);
        send_frame(pl, xsum(pl), 0, 0, 4);

        // Abort mid-payload, then a good frame.
        abort_frame(7);
        rand_payload(pl, 1'b0);
        send_frame(pl, xsum(pl), 1, 0, -1);

        // Async reset mid-frame.
        send_byte(SYNC_BYTE, c);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), c);
        i_in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        m_prog = '0; m_valid = 1'b0; m_err = 2'b00;
        check_idle_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back good frames with in_valid held high.
        rand_payload(pl, 1'b0);
        rand_payload(pl2, 1'b0);
        send_frame(pl, xsum(pl), 0, 1, -1);
        send_frame(pl2, xsum(pl2), 0, 0, -1);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(1, 0) == 1) begin
                do j = 8'($urandom); while (j == SYNC_BYTE);
                send_byte(j, c);
                i_in_valid = 1'b0;
            end
            mode = int'($urandom_range(4, 0));
            case (mode)
                2: begin
                    rand_payload(pl, 1'b0);
                    send_frame(pl, xsum(pl) ^ 8'($urandom_range(255, 1)), 3, 0, -1);
                end
                3: begin
                    rand_payload(pl, 1'b1);
                    send_frame(pl, xsum(pl), 3, 0, -1);
                end
                4: abort_frame(int'($urandom_range(NB, 0)));
                default: begin
                    rand_payload(pl, 1'b0);
                    send_frame(pl, xsum(pl), 3, 1'($urandom_range(1, 0)), -1);
                end
            endcase
        end

        i_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("final_prog", 128'(o_prog_out), 128'(m_prog));
        chk("final_code", 128'(o_err_code), 128'(m_err));
        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
